// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC manager.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ACQ  = 2'd2,
    ST_GAP  = 2'd3
  } adc_state_t;

  // Register command length in bits, shifted MSB first.
  localparam int unsigned CMD_WIDTH = 24;

  // Idle cycles with chip select high between transactions.
  localparam int unsigned GAP_LEN   = 2;
  localparam int unsigned GAP_CNT_W = 2;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: sck generation, bit counting, command shift-out
// and multi-lane conversion shift-in. One bit period is two clk cycles.
module spi_shift_engine
  import adc_pkg::*;
#(
  parameter int unsigned NUM_SDI    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  tx_mode_i,
  input  logic [CMD_WIDTH-1:0]  tx_data_i,
  input  logic [NUM_SDI-1:0]    sdi_i,
  output logic                  sck_o,
  output logic                  sdo_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rx_data_o
);

  localparam int unsigned RX_BITS  = DATA_WIDTH / NUM_SDI;
  localparam int unsigned MAX_BITS = (RX_BITS > CMD_WIDTH) ? RX_BITS : CMD_WIDTH;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

  logic                  busy_q, busy_d;
  logic                  sck_q, sck_d;
  logic                  mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]  tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;

  // Next state: sample at the end of the low phase, shift out at the end of the high phase.
  always_comb begin
    busy_d = busy_q;
    sck_d  = sck_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (start_i) begin
      busy_d = 1'b1;
      sck_d  = 1'b0;
      mode_d = tx_mode_i;
      cnt_d  = tx_mode_i ? CNT_W'(CMD_WIDTH) : CNT_W'(RX_BITS);
      tx_d   = tx_data_i;
      rx_d   = '0;
    end else if (busy_q) begin
      if (!sck_q) begin
        sck_d = 1'b1;
        if (!mode_q) begin
          rx_d = (rx_q << NUM_SDI) | DATA_WIDTH'(sdi_i);
        end
      end else begin
        sck_d = 1'b0;
        tx_d  = tx_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_d = 1'b0;
        end
      end
    end
  end

  // Engine state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sck_q  <= sck_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign sck_o     = sck_q;
  assign sdo_o     = busy_q & mode_q & tx_q[CMD_WIDTH-1];
  assign done_o    = busy_q & sck_q & (cnt_q == CNT_W'(1));
  assign rx_data_o = rx_q;

endmodule

// File: rtl/adc_manager.sv
// ADC manager: serialises register commands from AXI-Stream to the ADC and
// reads conversion results over NUM_SDI lanes on a trigger rising edge.
module adc_manager
  import adc_pkg::*;
#(
  parameter int unsigned NUM_SDI    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_SDI-1:0]    spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_sck,
  output logic                  spi_csn,
  output logic                  spi_resetn,
  input  logic                  trigger,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           status
);

  adc_state_t            state_q, state_d;
  logic [GAP_CNT_W-1:0]  gap_q, gap_d;
  logic                  tready_q;
  logic                  trig_q, trig_prev_q;
  logic                  trig_rise;
  logic                  spi_resetn_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic [15:0]           count_q;
  logic                  ovr_q;
  logic                  eng_start, eng_tx_mode, eng_done;
  logic [DATA_WIDTH-1:0] eng_rx;
  logic                  unused_tdata_hi;

  // Upper command byte is don't-care.
  assign unused_tdata_hi = ^s_axis_tdata[31:24];

  // Edge detect from registered trigger so tready can be masked without an input-to-output path.
  assign trig_rise = trig_q & ~trig_prev_q;

  // State register, gap counter, registered tready and trigger history.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      tready_q    <= 1'b0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      tready_q    <= (state_d == ST_IDLE);
      trig_q      <= trigger;
      trig_prev_q <= trig_q;
    end
  end

  // Next-state logic: trigger takes priority over a pending command in IDLE.
  always_comb begin
    state_d = state_q;
    gap_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (trig_rise) begin
          state_d = ST_ACQ;
        end else if (s_axis_tvalid && tready_q) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD, ST_ACQ: begin
        if (eng_done) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_CNT_W'(GAP_LEN - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: engine start on leaving IDLE, chip select during a transfer.
  always_comb begin
    eng_start     = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    eng_tx_mode   = (state_d == ST_CMD);
    spi_csn       = !((state_q == ST_CMD) || (state_q == ST_ACQ));
    s_axis_tready = tready_q & ~trig_rise;
  end

  // Registered copy of the system reset for the ADC.
  always_ff @(posedge aclk) begin
    spi_resetn_q <= aresetn;
  end

  // Result register: a new result overwrites an unconsumed one and flags overrun.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (eng_done && (state_q == ST_ACQ)) begin
        tdata_q  <= eng_rx;
        tvalid_q <= 1'b1;
        count_q  <= count_q + 16'd1;
        if (tvalid_q && !m_axis_tready) begin
          ovr_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  spi_shift_engine #(
    .NUM_SDI    (NUM_SDI),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_engine (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .start_i   (eng_start),
    .tx_mode_i (eng_tx_mode),
    .tx_data_i (s_axis_tdata[CMD_WIDTH-1:0]),
    .sdi_i     (spi_sdi),
    .sck_o     (spi_sck),
    .sdo_o     (spi_sdo),
    .done_o    (eng_done),
    .rx_data_o (eng_rx)
  );

  assign spi_resetn    = spi_resetn_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign status        = {count_q, 12'b0, ovr_q, tvalid_q, state_q};

endmodule

// File: tb/tb_adc_manager.sv
// Randomised bench for adc_manager with a behavioural ADC and result model.
module tb_adc_manager;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [N-1:0]  spi_sdi;
  logic          spi_sdo, spi_sck, spi_csn, spi_resetn;
  logic          trigger;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready;
  logic [31:0]   status;

  adc_manager #(.NUM_SDI(N), .DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .spi_sdi       (spi_sdi),
    .spi_sdo       (spi_sdo),
    .spi_sck       (spi_sck),
    .spi_csn       (spi_csn),
    .spi_resetn    (spi_resetn),
    .trigger       (trigger),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .status        (status)
  );

  always #5 aclk = ~aclk;

  // ---------------- behavioural ADC ----------------
  logic [DW-1:0] adc_pattern;
  logic [23:0]   rx_sh, last_cmd;
  int            rise_tot = 0, fall_tot = 0, rise_base = 0, fall_base = 0;
  int            last_sck = 0;
  int            sck_viol = 0;
  logic [DW-1:0] sdi_sh;

  always @(posedge spi_sck) begin
    rise_tot = rise_tot + 1;
    rx_sh    = {rx_sh[22:0], spi_sdo};
  end
  always @(negedge spi_sck) fall_tot = fall_tot + 1;
  always @(negedge spi_csn) begin
    rise_base = rise_tot;
    fall_base = fall_tot;
  end
  always @(posedge spi_csn) begin
    last_sck = rise_tot - rise_base;
    last_cmd = rx_sh;
  end
  // Group k (k = sck falling edges since csn fell) is the k-th N-bit chunk from the MSB.
  assign sdi_sh  = adc_pattern << ((fall_tot - fall_base) * N);
  assign spi_sdi = sdi_sh[DW-1 -: N];

  always @(negedge aclk) if (spi_csn === 1'b1 && spi_sck === 1'b1) sck_viol = sck_viol + 1;

  // ---------------- result model and checking ----------------
  int unsigned   exp_count = 0;
  bit            exp_ovr = 0, model_valid = 0;
  logic [DW-1:0] model_data = '0;
  int            n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, status[31:16], exp_count[15:0]);
    check({tag, ".ovr"}, status[3], exp_ovr);
    check({tag, ".valid"}, status[2], model_valid);
    check({tag, ".zero"}, status[15:4], 12'h000);
  endtask

  task automatic send_cmd(input logic [31:0] d);
    bit hs = 0;
    int lowc = 0, gapc = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 400 && !hs; k++) begin
      if (s_axis_tready) hs = 1;
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b0;
    check("cmd.handshake", hs, 1);
    check("cmd.tready_drop", s_axis_tready, 0);
    check("cmd.state", status[1:0], 1);
    for (int k = 0; k < 400; k++) begin
      if (status[1:0] == 2'd0) break;
      if (!spi_csn) lowc++;
      if (status[1:0] == 2'd3) gapc++;
      @(negedge aclk);
    end
    check("cmd.csn_low_cycles", lowc, 48);
    check("cmd.gap_cycles", gapc, 2);
    check("cmd.sck_edges", last_sck, 24);
    check("cmd.adc_rx", last_cmd, d[23:0]);
    check("cmd.tready_back", s_axis_tready, 1);
  endtask

  task automatic model_result(input logic [DW-1:0] pat, input bit rdy);
    exp_count++;
    if (rdy) begin
      model_valid = 0;
    end else begin
      if (model_valid) exp_ovr = 1;
      model_valid = 1;
      model_data  = pat;
    end
  endtask

  task automatic readout(input logic [DW-1:0] pat, input bit rdy, input int hold);
    int cyc = 0, lowc = 0, gapc = 0, vcyc = 0;
    bit busy_seen = 0;
    logic [DW-1:0] got = '0;
    adc_pattern   = pat;
    m_axis_tready = rdy;
    trigger       = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge aclk);
      cyc++;
      if (cyc == hold) trigger = 1'b0;
      if (m_axis_tvalid) begin
        vcyc++;
        got = m_axis_tdata;
      end
      if (status[1:0] != 2'd0) busy_seen = 1;
      if (!spi_csn) lowc++;
      if (status[1:0] == 2'd3) gapc++;
      if (busy_seen && status[1:0] == 2'd0 && cyc >= hold) break;
    end
    trigger = 1'b0;
    model_result(pat, rdy);
    check("ro.csn_low_cycles", lowc, 2 * DW / N);
    check("ro.gap_cycles", gapc, 2);
    check("ro.sck_edges", last_sck, DW / N);
    if (rdy) begin
      check("ro.valid_cycles", vcyc, 1);
      check("ro.data_seen", got, pat);
    end else begin
      check("ro.tdata", m_axis_tdata, model_data);
      check("ro.tvalid", m_axis_tvalid, 1);
    end
    check_status("ro");
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] p;
    logic [31:0]   c;
    int            vbad;

    aresetn = 1'b0; trigger = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0; adc_pattern = '0;
    repeat (4) @(negedge aclk);
    check("rst.status", status, 32'h0);
    check("rst.csn", spi_csn, 1);
    check("rst.sck", spi_sck, 0);
    check("rst.sdo", spi_sdo, 0);
    check("rst.tready", s_axis_tready, 0);
    check("rst.tvalid", m_axis_tvalid, 0);
    check("rst.tdata", m_axis_tdata, 0);
    check("rst.spi_resetn", spi_resetn, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel.tready", s_axis_tready, 1);
    check("rel.spi_resetn", spi_resetn, 1);

    // Commands, including the back-to-back pair and random upper bytes.
    send_cmd(32'h00A00000);
    send_cmd(32'h00002080);
    send_cmd(32'h00001401);
    check("cmd.last_received", last_cmd, 24'h001401);
    for (int i = 0; i < 4; i++) begin
      c = $urandom;
      send_cmd(c);
    end

    // Fixed-pattern readouts.
    readout(32'h8BADF00D, 1'b0, 3);
    check("ro1.count_is_one", status[31:16], 16'd1);
    m_axis_tready = 1'b1;
    @(negedge aclk);
    model_valid = 0;
    m_axis_tready = 1'b0;
    check("drain.tvalid_clear", m_axis_tvalid, 0);
    readout(32'h0023FF42, 1'b1, 3);

    // Two unconsumed readouts: second value held, overrun set.
    p = $urandom; readout(p, 1'b0, 2);
    p = $urandom; readout(p, 1'b0, 4);
    check("ovr.sticky", status[3], 1);

    // Random readouts; some hold trigger high well past the transfer.
    for (int i = 0; i < 6; i++) begin
      p = $urandom;
      readout(p, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 60 : int'($urandom_range(1, 4)));
    end

    // Trigger and command pending together: readout first, then command.
    p = $urandom; c = $urandom;
    adc_pattern = p; m_axis_tready = 1'b0;
    trigger = 1'b1;
    @(negedge aclk);
    s_axis_tdata = c; s_axis_tvalid = 1'b1;
    check("prio.tready_masked", s_axis_tready, 0);
    @(negedge aclk);
    trigger = 1'b0;
    check("prio.state_acq", status[1:0], 2);
    send_cmd(c);
    model_result(p, 1'b0);
    check("prio.tdata", m_axis_tdata, model_data);
    check_status("prio");

    // Trigger edge during a command is dropped.
    c = $urandom;
    fork
      send_cmd(c);
      begin
        repeat (10) @(negedge aclk);
        trigger = 1'b1;
        repeat (3) @(negedge aclk);
        trigger = 1'b0;
      end
    join
    repeat (5) @(negedge aclk);
    check("ign.state_idle", status[1:0], 0);
    check_status("ign");

    // Reset in the middle of a readout.
    adc_pattern = $urandom;
    trigger = 1'b1;
    repeat (3) @(negedge aclk);
    trigger = 1'b0;
    repeat (3) @(negedge aclk);
    check("mid.in_acq", status[1:0], 2);
    aresetn = 1'b0;
    @(negedge aclk);
    exp_count = 0; exp_ovr = 0; model_valid = 0;
    check("mid.csn", spi_csn, 1);
    check("mid.sck", spi_sck, 0);
    check("mid.status", status, 32'h0);
    check("mid.tvalid", m_axis_tvalid, 0);
    check("mid.tready", s_axis_tready, 0);
    check("mid.spi_resetn", spi_resetn, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid.tready_after", s_axis_tready, 1);
    vbad = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_axis_tvalid) vbad++;
      @(negedge aclk);
    end
    check("mid.no_partial", vbad, 0);
    check("mid.status_after", status, 32'h0);

    check("sck_idle_when_csn_high", sck_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
